dispatch_issue: RTL and testbench
=================================

# dispatch_issue

Reader end of the decode queue. Each cycle it examines the two head entries presented by the decoder queue and checks them against a register scoreboard and the dual-issue pairing rules. It issues zero, one or two instructions into registered issue slots toward the execute pipes. It returns the per-slot dequeue acknowledge `invalid_en` that retires the consumed queue entries.

## Interface
Parameters:
- `WB_PORTS`, default 2. Number of writeback ports that clear scoreboard bits.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `flush` in 1: pipeline flush.
- `exe_stall` in 1: execute cannot accept new instructions.
- `dq_inst_valid` in 2: head-entry valid, bit i = queue slot i.
- `dq_pc`, `dq_inst`, `dq_imm` in 2×32: queue payload.
- `dq_aluop` in 2×8, `dq_alusel` in 2×3: queue payload.
- `dq_reg1_en`, `dq_reg2_en`, `dq_rd_en` in 2: source read enables and destination write enable.
- `dq_reg1_addr`, `dq_reg2_addr`, `dq_rd_addr` in 2×5: source and destination register addresses.
- `dq_is_privilege`, `dq_csr_we` in 2: serialising-instruction flags.
- `dq_is_exception` in 2×3, `dq_exception_cause` in 2×3×7: exception flags and causes.
- `wb_en` in WB_PORTS, `wb_addr` in WB_PORTS×5: writeback scoreboard clears.
- `invalid_en` out 2: dequeue acknowledge, combinational. Legal values are 00, 01 and 11 only.
- `issue_valid` out 2, plus registered copies of every payload field above per pipe (`issue_pc`, `issue_inst`, …, `issue_exception_cause`).

## Operation
- **Scoreboard:** `busy[31:0]`, where bit r set means an issued, not-yet-written-back instruction writes register r. `busy[0]` is always 0.
- **Effective busy:** `busy & ~wb_clear`. `wb_clear` is the OR of `wb_en[k]` decoded on `wb_addr[k]`, so a same-cycle writeback unblocks a waiting instruction.
- **Slot 0 is ready** when `dq_inst_valid[0]`, `!exe_stall`, `!flush`, and every enabled source address is not effective-busy. An enabled rd that is effective-busy also blocks (WAW).
- **Slot 1 is ready** when slot 0 issues and slot 1 passes the same scoreboard checks. In addition:
  - No RAW on slot 0: slot 0 has rd_en and rd≠0, and slot 1 reads that register.
  - No WAW: both slots write the same non-zero rd.
  - Neither slot has `is_privilege`, `csr_we`, or any `is_exception` bit set.
- **Dequeue:** `invalid_en = {issue1, issue0}`. Slot 1 never issues without slot 0, so the queue always retires in order.
- **Scoreboard update on the clock edge:**
  - `busy <= (busy & ~wb_clear) | set_mask`.
  - `set_mask` has a bit for each issued slot with rd_en and rd≠0.
  - If the same register is both set and cleared in one cycle, set wins.
- **Issue registers:**
  - When `!exe_stall`, `issue_valid[i] <= issue_i`, and the payload is loaded from `dq_*` for issued slots.
  - Payload of non-issued slots is don't-care.
  - When `exe_stall`, all issue registers hold.
- **Flush:**
  - `invalid_en = 00` in the flush cycle.
  - Next edge: `issue_valid <= 00` and `busy <= 0`; this overrides `exe_stall` hold.
- A writeback to a non-busy register has no effect. Writebacks to r0 are ignored.

## Timing
- Reset (`rst` = 0, asynchronous): `issue_valid` = 00, all issue payload = 0, `busy` = 0.
  - `invalid_en` is 00 while in reset, since it is gated by the `rst` level.
- Issue latency: 1 cycle from the queue head being valid and ready to `issue_valid` high.
- `invalid_en` is combinational in the same cycle as the decision. The queue must advance on that edge.
- Back-to-back dependent pair arriving in different cycles: the consumer stalls until `wb_en` for the producer's rd. It issues in the same cycle as that `wb_en`, so the edge after the writeback shows `issue_valid`.
- `exe_stall` and `flush` asserted in the same cycle: flush wins.
- Reset released mid-stream: the first edge after release evaluates normally. No issue is held over from before reset.

## Configuration
- Macro `DISPATCH_DUAL_ISSUE_EN`.
- Defined: the pairing rules above; up to two issues per cycle.
- Undefined: slot 1 never issues. `invalid_en[1]` and `issue_valid[1]` are tied 0, and `issue_valid[1]` stays 0 in all cases. The scoreboard and slot-0 rules are unchanged.

## Test plan
- **Independent pair:** `add r1,r2,r3` and `add r4,r5,r6` valid, all not busy → `invalid_en` = 11. Next edge `issue_valid` = 11, `busy[1]` = `busy[4]` = 1.
- **Intra-pair RAW:** slot 0 writes r5, slot 1 reads r5 → `invalid_en` = 01. Next cycle the old slot 1 is the head and is blocked by `busy[5]` until `wb_en` on r5, then issues in that same cycle.
- **Privileged slot 0** (`csr_we` = 1) with a valid independent slot 1 → `invalid_en` = 01 each cycle; the CSR instruction issues alone.
- **Stall:** `exe_stall` = 1 for 3 cycles with a ready pair → `invalid_en` = 00 and the issue registers hold their previous values. On stall release the pair issues.
- **Flush with stall:** flush asserted together with `exe_stall` while `busy[7]` = 1 → next edge `issue_valid` = 00 and `busy` = 0. A reader of r7 then issues immediately.
- **Async reset mid-operation:** `rst` pulled low between edges → outputs zero immediately without a clock edge. With the macro undefined, repeat the first scenario → `invalid_en` = 01.

Source files
------------

// File: rtl/dispatch_issue.sv
// Decode-queue reader: scoreboard check, dual-issue pairing and registered issue slots.
// Optional feature: define DISPATCH_DUAL_ISSUE_EN to allow slot 1 to pair with slot 0.
module dispatch_issue #(
    parameter int WB_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       exe_stall,
    input  logic [1:0]                 dq_inst_valid,
    input  logic [1:0][31:0]           dq_pc,
    input  logic [1:0][31:0]           dq_inst,
    input  logic [1:0][31:0]           dq_imm,
    input  logic [1:0][7:0]            dq_aluop,
    input  logic [1:0][2:0]            dq_alusel,
    input  logic [1:0]                 dq_reg1_en,
    input  logic [1:0]                 dq_reg2_en,
    input  logic [1:0]                 dq_rd_en,
    input  logic [1:0][4:0]            dq_reg1_addr,
    input  logic [1:0][4:0]            dq_reg2_addr,
    input  logic [1:0][4:0]            dq_rd_addr,
    input  logic [1:0]                 dq_is_privilege,
    input  logic [1:0]                 dq_csr_we,
    input  logic [1:0][2:0]            dq_is_exception,
    input  logic [1:0][2:0][6:0]       dq_exception_cause,
    input  logic [WB_PORTS-1:0]        wb_en,
    input  logic [WB_PORTS-1:0][4:0]   wb_addr,
    output logic [1:0]                 invalid_en,
    output logic [1:0]                 issue_valid,
    output logic [1:0][31:0]           issue_pc,
    output logic [1:0][31:0]           issue_inst,
    output logic [1:0][31:0]           issue_imm,
    output logic [1:0][7:0]            issue_aluop,
    output logic [1:0][2:0]            issue_alusel,
    output logic [1:0]                 issue_reg1_en,
    output logic [1:0]                 issue_reg2_en,
    output logic [1:0]                 issue_rd_en,
    output logic [1:0][4:0]            issue_reg1_addr,
    output logic [1:0][4:0]            issue_reg2_addr,
    output logic [1:0][4:0]            issue_rd_addr,
    output logic [1:0]                 issue_is_privilege,
    output logic [1:0]                 issue_csr_we,
    output logic [1:0][2:0]            issue_is_exception,
    output logic [1:0][2:0][6:0]       issue_exception_cause
);

    logic [31:0]                busy_reg;
    logic [WB_PORTS-1:0][31:0]  wb_dec;
    logic [31:0]                wb_clear;
    logic [31:0]                eff_busy;
    logic [31:0]                set_mask;
    logic [1:0]                 slot_ok;
    logic [1:0]                 serial;
    logic [1:0]                 issue;

    genvar gi;
    generate
        for (gi = 0; gi < WB_PORTS; gi++) begin : g_wb
            assign wb_dec[gi] = wb_en[gi] ? (32'd1 << wb_addr[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        wb_clear = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            wb_clear = wb_clear | wb_dec[k];
        end
        wb_clear[0] = 1'b0;
    end

    // A same-cycle writeback already releases its register for this decision.
    assign eff_busy = busy_reg & ~wb_clear;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_ok[gi] = !(dq_reg1_en[gi] && eff_busy[dq_reg1_addr[gi]]) &&
                                 !(dq_reg2_en[gi] && eff_busy[dq_reg2_addr[gi]]) &&
                                 !(dq_rd_en[gi]   && eff_busy[dq_rd_addr[gi]]);
            assign serial[gi]  = dq_is_privilege[gi] | dq_csr_we[gi] | (|dq_is_exception[gi]);
        end
    endgenerate

    assign issue[0] = rst && dq_inst_valid[0] && !exe_stall && !flush && slot_ok[0];

`ifdef DISPATCH_DUAL_ISSUE_EN
    logic pair_raw;
    logic pair_waw;

    assign pair_raw = dq_rd_en[0] && (dq_rd_addr[0] != 5'd0) &&
                      ((dq_reg1_en[1] && (dq_reg1_addr[1] == dq_rd_addr[0])) ||
                       (dq_reg2_en[1] && (dq_reg2_addr[1] == dq_rd_addr[0])));
    assign pair_waw = dq_rd_en[0] && dq_rd_en[1] && (dq_rd_addr[0] != 5'd0) &&
                      (dq_rd_addr[0] == dq_rd_addr[1]);
    assign issue[1] = issue[0] && dq_inst_valid[1] && slot_ok[1] &&
                      !pair_raw && !pair_waw && !serial[0] && !serial[1];
`else
    logic unused_slot1;

    assign unused_slot1 = dq_inst_valid[1] ^ slot_ok[1] ^ serial[1] ^ serial[0];
    assign issue[1]     = 1'b0;
`endif

    assign invalid_en = issue;

    always_comb begin
        set_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (issue[i] && dq_rd_en[i]) begin
                set_mask[dq_rd_addr[i]] = 1'b1;
            end
        end
        set_mask[0] = 1'b0;
    end

    // OR-ing set_mask after the clear makes a same-register set win over a writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg <= '0;
        end else if (flush) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= eff_busy | set_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid           <= '0;
            issue_pc              <= '0;
            issue_inst            <= '0;
            issue_imm             <= '0;
            issue_aluop           <= '0;
            issue_alusel          <= '0;
            issue_reg1_en         <= '0;
            issue_reg2_en         <= '0;
            issue_rd_en           <= '0;
            issue_reg1_addr       <= '0;
            issue_reg2_addr       <= '0;
            issue_rd_addr         <= '0;
            issue_is_privilege    <= '0;
            issue_csr_we          <= '0;
            issue_is_exception    <= '0;
            issue_exception_cause <= '0;
        end else if (flush || !exe_stall) begin
            // issue is forced to 00 during flush, so this also clears the slots.
            issue_valid <= issue;
            for (int i = 0; i < 2; i++) begin
                if (issue[i]) begin
                    issue_pc[i]              <= dq_pc[i];
                    issue_inst[i]            <= dq_inst[i];
                    issue_imm[i]             <= dq_imm[i];
                    issue_aluop[i]           <= dq_aluop[i];
                    issue_alusel[i]          <= dq_alusel[i];
                    issue_reg1_en[i]         <= dq_reg1_en[i];
                    issue_reg2_en[i]         <= dq_reg2_en[i];
                    issue_rd_en[i]           <= dq_rd_en[i];
                    issue_reg1_addr[i]       <= dq_reg1_addr[i];
                    issue_reg2_addr[i]       <= dq_reg2_addr[i];
                    issue_rd_addr[i]         <= dq_rd_addr[i];
                    issue_is_privilege[i]    <= dq_is_privilege[i];
                    issue_csr_we[i]          <= dq_csr_we[i];
                    issue_is_exception[i]    <= dq_is_exception[i];
                    issue_exception_cause[i] <= dq_exception_cause[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_issue.sv
// Directed self-checking bench for dispatch_issue; expectations follow DISPATCH_DUAL_ISSUE_EN.
module tb_dispatch_issue;

`ifdef DISPATCH_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic                  exe_stall;
    logic [1:0]            dq_inst_valid;
    logic [1:0][31:0]      dq_pc, dq_inst, dq_imm;
    logic [1:0][7:0]       dq_aluop;
    logic [1:0][2:0]       dq_alusel;
    logic [1:0]            dq_reg1_en, dq_reg2_en, dq_rd_en;
    logic [1:0][4:0]       dq_reg1_addr, dq_reg2_addr, dq_rd_addr;
    logic [1:0]            dq_is_privilege, dq_csr_we;
    logic [1:0][2:0]       dq_is_exception;
    logic [1:0][2:0][6:0]  dq_exception_cause;
    logic [1:0]            wb_en;
    logic [1:0][4:0]       wb_addr;
    logic [1:0]            invalid_en;
    logic [1:0]            issue_valid;
    logic [1:0][31:0]      issue_pc, issue_inst, issue_imm;
    logic [1:0][7:0]       issue_aluop;
    logic [1:0][2:0]       issue_alusel;
    logic [1:0]            issue_reg1_en, issue_reg2_en, issue_rd_en;
    logic [1:0][4:0]       issue_reg1_addr, issue_reg2_addr, issue_rd_addr;
    logic [1:0]            issue_is_privilege, issue_csr_we;
    logic [1:0][2:0]       issue_is_exception;
    logic [1:0][2:0][6:0]  issue_exception_cause;

    int vectors = 0;
    int errors  = 0;

    dispatch_issue #(.WB_PORTS(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .exe_stall(exe_stall),
        .dq_inst_valid(dq_inst_valid), .dq_pc(dq_pc), .dq_inst(dq_inst), .dq_imm(dq_imm),
        .dq_aluop(dq_aluop), .dq_alusel(dq_alusel),
        .dq_reg1_en(dq_reg1_en), .dq_reg2_en(dq_reg2_en), .dq_rd_en(dq_rd_en),
        .dq_reg1_addr(dq_reg1_addr), .dq_reg2_addr(dq_reg2_addr), .dq_rd_addr(dq_rd_addr),
        .dq_is_privilege(dq_is_privilege), .dq_csr_we(dq_csr_we),
        .dq_is_exception(dq_is_exception), .dq_exception_cause(dq_exception_cause),
        .wb_en(wb_en), .wb_addr(wb_addr), .invalid_en(invalid_en),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_inst(issue_inst),
        .issue_imm(issue_imm), .issue_aluop(issue_aluop), .issue_alusel(issue_alusel),
        .issue_reg1_en(issue_reg1_en), .issue_reg2_en(issue_reg2_en), .issue_rd_en(issue_rd_en),
        .issue_reg1_addr(issue_reg1_addr), .issue_reg2_addr(issue_reg2_addr),
        .issue_rd_addr(issue_rd_addr), .issue_is_privilege(issue_is_privilege),
        .issue_csr_we(issue_csr_we), .issue_is_exception(issue_is_exception),
        .issue_exception_cause(issue_exception_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        flush = 0; exe_stall = 0; dq_inst_valid = '0;
        dq_pc = '0; dq_inst = '0; dq_imm = '0; dq_aluop = '0; dq_alusel = '0;
        dq_reg1_en = '0; dq_reg2_en = '0; dq_rd_en = '0;
        dq_reg1_addr = '0; dq_reg2_addr = '0; dq_rd_addr = '0;
        dq_is_privilege = '0; dq_csr_we = '0; dq_is_exception = '0; dq_exception_cause = '0;
        wb_en = '0; wb_addr = '0;
    endtask

    // add rd, a, b in queue slot s
    task automatic set_slot(input int s, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [4:0] a, input logic [4:0] b);
        dq_inst_valid[s] = 1'b1;
        dq_pc[s]   = pc;
        dq_inst[s] = {7'd0, b, a, 3'd0, rd, 7'h33};
        dq_imm[s]  = pc ^ 32'hA5A5_0000;
        dq_aluop[s] = 8'h20; dq_alusel[s] = 3'd1;
        dq_reg1_en[s] = 1'b1; dq_reg2_en[s] = 1'b1; dq_rd_en[s] = 1'b1;
        dq_reg1_addr[s] = a; dq_reg2_addr[s] = b; dq_rd_addr[s] = rd;
        dq_is_privilege[s] = 1'b0; dq_csr_we[s] = 1'b0;
        dq_is_exception[s] = '0; dq_exception_cause[s] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("txn t=%0t issue_valid=%b pc0=%h pc1=%h", $time, issue_valid, issue_pc[0], issue_pc[1]);
    endtask

    task automatic do_flush();
        clear_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        set_slot(0, 32'h10, 5'd1, 5'd2, 5'd3);
        #1;
        vectors++; if (invalid_en !== 2'b00) begin errors++; $display("FAIL reset_inv: got %b exp 00", invalid_en); end
        vectors++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL reset_iv: got %b exp 00", issue_valid); end
        step();
        vectors++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL reset_iv_edge: got %b exp 00", issue_valid); end
        vectors++; if (issue_pc !== '0) begin errors++; $display("FAIL reset_pc: got %h exp 0", issue_pc); end
        rst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_independent_pair();
        set_slot(0, 32'h100, 5'd1, 5'd2, 5'd3);
        set_slot(1, 32'h104, 5'd4, 5'd5, 5'd6);
        #1;
        vectors++; if (invalid_en !== (DUAL ? 2'b11 : 2'b01)) begin errors++; $display("FAIL pair_inv: got %b exp %b", invalid_en, DUAL ? 2'b11 : 2'b01); end
        step();
        vectors++; if (issue_valid !== (DUAL ? 2'b11 : 2'b01)) begin errors++; $display("FAIL pair_iv: got %b exp %b", issue_valid, DUAL ? 2'b11 : 2'b01); end
        vectors++; if (issue_pc[0] !== 32'h100) begin errors++; $display("FAIL pair_pc0: got %h exp 100", issue_pc[0]); end
        vectors++; if (issue_pc[1] !== (DUAL ? 32'h104 : 32'h0)) begin errors++; $display("FAIL pair_pc1: got %h exp %h", issue_pc[1], DUAL ? 32'h104 : 32'h0); end
        vectors++; if (issue_rd_addr[0] !== 5'd1) begin errors++; $display("FAIL pair_rd0: got %0d exp 1", issue_rd_addr[0]); end
        // r1 is now busy in both builds
        clear_inputs();
        set_slot(0, 32'h108, 5'd8, 5'd1, 5'd2);
        #1;
        vectors++; if (invalid_en !== 2'b00) begin errors++; $display("FAIL busy_r1_inv: got %b exp 00", invalid_en); end
        step();
        vectors++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL busy_r1_iv: got %b exp 00", issue_valid); end
        // r4 is busy only if slot 1 issued
        set_slot(0, 32'h10C, 5'd9, 5'd4, 5'd2);
        #1;
        vectors++; if (invalid_en !== (DUAL ? 2'b00 : 2'b01)) begin errors++; $display("FAIL busy_r4_inv: got %b exp %b", invalid_en, DUAL ? 2'b00 : 2'b01); end
        step();
        vectors++; if (issue_valid !== (DUAL ? 2'b00 : 2'b01)) begin errors++; $display("FAIL busy_r4_iv: got %b exp %b", issue_valid, DUAL ? 2'b00 : 2'b01); end
        set_slot(0, 32'h110, 5'd10, 5'd1, 5'd4);
        wb_en = 2'b11; wb_addr[0] = 5'd1; wb_addr[1] = 5'd4;
        #1;
        vectors++; if (invalid_en !== 2'b01) begin errors++; $display("FAIL wb_bypass_inv: got %b exp 01", invalid_en); end
        step();
        vectors++; if (issue_pc[0] !== 32'h110) begin errors++; $display("FAIL wb_bypass_pc: got %h exp 110", issue_pc[0]); end
        do_flush();
    endtask

    task automatic test_intra_raw();
        set_slot(0, 32'h200, 5'd5, 5'd2, 5'd3);
        set_slot(1, 32'h204, 5'd6, 5'd5, 5'd0);
        #1;
        vectors++; if (invalid_en !== 2'b01) begin errors++; $display("FAIL raw_inv: got %b exp 01", invalid_en); end
        step();
        vectors++; if (issue_valid !== 2'b01) begin errors++; $display("FAIL raw_iv: got %b exp 01", issue_valid); end
        clear_inputs();
        set_slot(0, 32'h204, 5'd6, 5'd5, 5'd0);
        #1;
        vectors++; if (invalid_en !== 2'b00) begin errors++; $display("FAIL raw_wait_inv: got %b exp 00", invalid_en); end
        step();
        vectors++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL raw_wait_iv: got %b exp 00", issue_valid); end
        wb_en[0] = 1'b1; wb_addr[0] = 5'd5;
        #1;
        vectors++; if (invalid_en !== 2'b01) begin errors++; $display("FAIL raw_wb_inv: got %b exp 01", invalid_en); end
        step();
        vectors++; if (issue_valid !== 2'b01) begin errors++; $display("FAIL raw_wb_iv: got %b exp 01", issue_valid); end
        vectors++; if (issue_pc[0] !== 32'h204) begin errors++; $display("FAIL raw_wb_pc: got %h exp 204", issue_pc[0]); end
        do_flush();
    endtask

    task automatic test_waw_pair();
        set_slot(0, 32'h280, 5'd20, 5'd1, 5'd2);
        set_slot(1, 32'h284, 5'd20, 5'd3, 5'd4);
        #1;
        vectors++; if (invalid_en !== 2'b01) begin errors++; $display("FAIL waw_inv: got %b exp 01", invalid_en); end
        step();
        do_flush();
    endtask

    task automatic test_privilege();
        set_slot(0, 32'h300, 5'd9, 5'd1, 5'd2);
        dq_csr_we[0] = 1'b1;
        set_slot(1, 32'h304, 5'd10, 5'd11, 5'd12);
        #1;
        vectors++; if (invalid_en !== 2'b01) begin errors++; $display("FAIL priv_inv: got %b exp 01", invalid_en); end
        step();
        vectors++; if (issue_csr_we[0] !== 1'b1) begin errors++; $display("FAIL priv_csr: got %b exp 1", issue_csr_we[0]); end
        clear_inputs();
        set_slot(0, 32'h304, 5'd10, 5'd11, 5'd12);
        #1;
        vectors++; if (invalid_en !== 2'b01) begin errors++; $display("FAIL priv_next_inv: got %b exp 01", invalid_en); end
        step();
        vectors++; if (issue_pc[0] !== 32'h304) begin errors++; $display("FAIL priv_next_pc: got %h exp 304", issue_pc[0]); end
        do_flush();
    endtask

    task automatic test_stall();
        set_slot(0, 32'h400, 5'd13, 5'd14, 5'd15);
        step();
        clear_inputs();
        set_slot(0, 32'h500, 5'd16, 5'd17, 5'd18);
        set_slot(1, 32'h504, 5'd19, 5'd20, 5'd21);
        exe_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (invalid_en !== 2'b00) begin errors++; $display("FAIL stall_inv%0d: got %b exp 00", c, invalid_en); end
            step();
            vectors++; if (issue_valid !== 2'b01 || issue_pc[0] !== 32'h400) begin errors++; $display("FAIL stall_hold%0d: got iv=%b pc=%h exp iv=01 pc=400", c, issue_valid, issue_pc[0]); end
        end
        exe_stall = 1'b0;
        #1;
        vectors++; if (invalid_en !== (DUAL ? 2'b11 : 2'b01)) begin errors++; $display("FAIL stall_rel_inv: got %b exp %b", invalid_en, DUAL ? 2'b11 : 2'b01); end
        step();
        vectors++; if (issue_pc[0] !== 32'h500) begin errors++; $display("FAIL stall_rel_pc: got %h exp 500", issue_pc[0]); end
        do_flush();
    endtask

    task automatic test_flush_with_stall();
        set_slot(0, 32'h600, 5'd7, 5'd1, 5'd2);
        step();
        clear_inputs();
        set_slot(0, 32'h604, 5'd11, 5'd7, 5'd0);
        flush = 1'b1; exe_stall = 1'b1;
        #1;
        vectors++; if (invalid_en !== 2'b00) begin errors++; $display("FAIL flush_inv: got %b exp 00", invalid_en); end
        step();
        vectors++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL flush_iv: got %b exp 00", issue_valid); end
        flush = 1'b0; exe_stall = 1'b0;
        #1;
        vectors++; if (invalid_en !== 2'b01) begin errors++; $display("FAIL flush_r7_inv: got %b exp 01", invalid_en); end
        step();
        vectors++; if (issue_valid !== 2'b01 || issue_pc[0] !== 32'h604) begin errors++; $display("FAIL flush_r7_iv: got iv=%b pc=%h exp iv=01 pc=604", issue_valid, issue_pc[0]); end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        set_slot(0, 32'h700, 5'd22, 5'd1, 5'd2);
        rst = 1'b0;
        #1;
        vectors++; if (issue_valid !== 2'b00 || issue_pc[0] !== 32'h0) begin errors++; $display("FAIL async_rst: got iv=%b pc=%h exp iv=00 pc=0", issue_valid, issue_pc[0]); end
        vectors++; if (invalid_en !== 2'b00) begin errors++; $display("FAIL async_rst_inv: got %b exp 00", invalid_en); end
        step();
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (invalid_en !== 2'b01) begin errors++; $display("FAIL rst_release_inv: got %b exp 01", invalid_en); end
        step();
        vectors++; if (issue_valid !== 2'b01 || issue_pc[0] !== 32'h700) begin errors++; $display("FAIL rst_release_iv: got iv=%b pc=%h exp iv=01 pc=700", issue_valid, issue_pc[0]); end
    endtask

    initial begin
        test_reset();
        test_independent_pair();
        test_intra_raw();
        test_waw_pair();
        test_privilege();
        test_stall();
        test_flush_with_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
